weight_load_sched: RTL and testbench



---
 rtl/wsched_pkg.sv | 24 ++
 rtl/wsched_burst_cnt.sv | 31 +++
 rtl/weight_load_sched.sv | 186 ++++++++++++++++++
 tb/tb_weight_load_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wsched_pkg.sv
// Shared definitions for the weight-load scheduler: state encoding, counter
// width and the configuration legality check.
package wsched_pkg;

    localparam int CNT_W     = 8;
    localparam int MAX_K_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A job needs at least one word per buffer, no more words than a buffer
    // holds, and at least one read pass.
    function automatic logic cfg_ok(input logic [CNT_W-1:0] k,
                                    input logic [CNT_W-1:0] np,
                                    input int unsigned      max_k);
        return (k != '0) && (32'(k) <= max_k) && (np != '0);
    endfunction

endpackage

// File: rtl/wsched_burst_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag against a
// runtime limit. Clear wins over increment.
module wsched_burst_cnt
    import wsched_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: clear has priority, then increment, otherwise hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/weight_load_sched.sv
// Weight-load scheduler: fills NUM_BUF weight buffers round-robin from one
// valid/ready stream, then issues num_passes read bursts on PE request.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; bad configuration raises cfg_err
//   ST_LOAD  | accepting kernel_size words per buffer, buffer 0 upward
//   ST_ARMED | buffers full, waiting for rd_req to launch a burst
//   ST_READ  | burst in progress, kernel_size cycles
//   ST_DONE  | one-cycle done pulse, then back to idle
module weight_load_sched
    import wsched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BUF    = 4,
    parameter int MAX_K      = MAX_K_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_W-1:0]      kernel_size,
    input  logic [CNT_W-1:0]      num_passes,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [NUM_BUF-1:0]    buf_flush,
    output logic [DATA_WIDTH-1:0] buf_data,
    input  logic                  rd_req,
    output logic                  rd_start,
    output logic                  rd_active,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int SEL_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_BUF - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_np;
    logic [SEL_W-1:0]   r_sel;
    logic               r_cfg_err;

    logic               w_cfg_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_load_go;
    logic               w_hs;
    logic               w_in_read;
    logic [CNT_W-1:0]   w_k_last;
    logic [CNT_W-1:0]   w_np_last;
    logic               w_wtc;
    logic               w_rtc;
    logic               w_ptc;
    logic               w_sel_last;
    logic [NUM_BUF-1:0] w_flush;

    assign w_cfg_ok  = cfg_ok(kernel_size, num_passes, MAX_K);
    assign w_accept  = (r_state == ST_IDLE) & start & w_cfg_ok & ~abort;
    assign w_reject  = (r_state == ST_IDLE) & start & ~w_cfg_ok & ~abort;

    // Abort suppresses the state-decoded strobes in the very cycle it arrives.
    assign w_load_go = (r_state == ST_LOAD) & ~abort;
    assign w_hs      = s_valid & w_load_go;
    assign w_in_read = (r_state == ST_READ) & ~abort;

    // k_r and np_r are never zero while in use, so these do not wrap.
    assign w_k_last   = r_k - CNT_W'(1);
    assign w_np_last  = r_np - CNT_W'(1);
    assign w_sel_last = (r_sel == SEL_LAST);

    // Words written into the current buffer; wraps on the buffer's last word.
    wsched_burst_cnt #(.W(CNT_W)) u_wcnt (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (abort | w_accept | (w_hs & w_wtc)),
        .i_inc    (w_hs),
        .i_tc_val (w_k_last),
        .o_tc     (w_wtc)
    );

    // Cycle position inside the current read burst.
    wsched_burst_cnt #(.W(CNT_W)) u_rcnt (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (abort | w_accept | rd_start),
        .i_inc    (w_in_read),
        .i_tc_val (w_k_last),
        .o_tc     (w_rtc)
    );

    // Completed read passes for this job.
    wsched_burst_cnt #(.W(CNT_W)) u_pcnt (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (abort | w_accept),
        .i_inc    (w_in_read & w_rtc),
        .i_tc_val (w_np_last),
        .o_tc     (w_ptc)
    );

    // Job configuration is captured only when a start is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k  <= '0;
            r_np <= '0;
        end else if (w_accept) begin
            r_k  <= kernel_size;
            r_np <= num_passes;
        end
    end

    // Buffer select advances after the last word of each buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel <= '0;
        end else if (abort | w_accept) begin
            r_sel <= '0;
        end else if (w_hs & w_wtc) begin
            r_sel <= w_sel_last ? '0 : r_sel + SEL_W'(1);
        end
    end

    // Rejected starts are flagged the cycle after, so the flag is clean in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && w_cfg_ok) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_hs && w_wtc && w_sel_last) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (rd_req) w_next = ST_READ;
            end
            ST_READ: begin
                if (w_rtc) w_next = w_ptc ? ST_DONE : ST_ARMED;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) w_next = ST_IDLE;
    end

    // One-hot write enable for the buffer currently being filled.
    always_comb begin
        w_flush = '0;
        if (w_hs) w_flush[r_sel] = 1'b1;
    end

    assign s_ready   = w_load_go;
    assign buf_flush = w_flush;
    assign buf_data  = (r_state == ST_LOAD) ? s_data : '0;
    assign rd_start  = (r_state == ST_ARMED) & rd_req & ~abort;
    assign rd_active = (r_state == ST_READ);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_weight_load_sched.sv
// Self-checking bench for weight_load_sched. Expected behaviour is derived
// from job-level rules: word n of a job lands in buffer n/k, each read burst
// is rd_start followed by k active cycles, and a job ends after np bursts.
module tb_weight_load_sched;

    localparam int DW = 16;
    localparam int NB = 4;
    localparam int MK = 16;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [7:0]    kernel_size;
    logic [7:0]    num_passes;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [NB-1:0] buf_flush;
    logic [DW-1:0] buf_data;
    logic          rd_req;
    logic          rd_start;
    logic          rd_active;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    weight_load_sched #(.DATA_WIDTH(DW), .NUM_BUF(NB), .MAX_K(MK)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .abort       (abort),
        .kernel_size (kernel_size),
        .num_passes  (num_passes),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .buf_flush   (buf_flush),
        .buf_data    (buf_data),
        .rd_req      (rd_req),
        .rd_start    (rd_start),
        .rd_active   (rd_active),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Inputs are driven at posedge+2 and outputs checked at posedge+3.
    task automatic next_cycle();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_ready"},   32'(s_ready),   32'd0);
        chk({tag, ".buf_flush"}, 32'(buf_flush), 32'd0);
        chk({tag, ".buf_data"},  32'(buf_data),  32'd0);
        chk({tag, ".rd_start"},  32'(rd_start),  32'd0);
        chk({tag, ".rd_active"}, 32'(rd_active), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".cfg_err"},   32'(cfg_err),   32'd0);
    endtask

    task automatic do_start(input int k, input int np);
        start       = 1'b1;
        kernel_size = 8'(k);
        num_passes  = 8'(np);
        #1;
        chk("start.busy_before", 32'(busy), 32'd0);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic do_reject(input int k, input int np);
        start       = 1'b1;
        kernel_size = 8'(k);
        num_passes  = 8'(np);
        #1;
        chk("reject.s_ready0", 32'(s_ready), 32'd0);
        next_cycle();
        start = 1'b0;
        #1;
        chk("reject.cfg_err", 32'(cfg_err), 32'd1);
        chk("reject.busy",    32'(busy),    32'd0);
        chk("reject.s_ready", 32'(s_ready), 32'd0);
        next_cycle();
        #1;
        chk("reject.cfg_err_clear", 32'(cfg_err), 32'd0);
        chk("reject.busy2",         32'(busy),    32'd0);
        next_cycle();
    endtask

    // vmode: 0 = valid held, data 1..N; 1 = valid toggles 1,0,1,0; 2 = random.
    task automatic do_load(input int k, input int nwords, input int vmode);
        int          n;
        int          writes;
        int          budget;
        logic        v;
        logic [31:0] ef;
        n      = 0;
        writes = 0;
        budget = 0;
        while (n < nwords && budget < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((budget % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = (vmode == 0) ? DW'(n + 1) : DW'($urandom);
            #1;
            ef = v ? (32'd1 << (n / k)) : 32'd0;
            chk("load.s_ready",   32'(s_ready),   32'd1);
            chk("load.buf_flush", 32'(buf_flush), ef);
            if (v) chk("load.buf_data", 32'(buf_data), 32'(s_data));
            if (buf_flush != '0) writes++;
            if (v) n++;
            next_cycle();
            budget++;
        end
        s_valid = 1'b0;
        chk("load.total_writes", 32'(writes), 32'(nwords));
    endtask

    // Starts in ARMED right after the final load handshake.
    task automatic do_read(input int k, input int np, input bit hold);
        int idle;
        int last_rs;
        last_rs = 0;
        for (int p = 0; p < np; p++) begin
            idle = hold ? 0 : $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                rd_req = 1'b0;
                #1;
                chk("armed.rd_start", 32'(rd_start),  32'd0);
                chk("armed.rd_active", 32'(rd_active), 32'd0);
                chk("armed.busy",      32'(busy),      32'd1);
                next_cycle();
            end
            rd_req = 1'b1;
            if (p == 0) s_valid = 1'b1;
            #1;
            chk("armed.rd_start_pulse", 32'(rd_start),  32'd1);
            chk("armed.no_active",      32'(rd_active), 32'd0);
            if (p == 0) begin
                chk("armed.s_ready",   32'(s_ready),   32'd0);
                chk("armed.buf_flush", 32'(buf_flush), 32'd0);
            end
            if (hold && p > 0) chk("read.rd_start_spacing", 32'(cyc - last_rs), 32'(k + 1));
            last_rs = cyc;
            s_valid = 1'b0;
            next_cycle();
            for (int c = 0; c < k; c++) begin
                rd_req = hold ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                chk("read.rd_active", 32'(rd_active), 32'd1);
                chk("read.rd_start",  32'(rd_start),  32'd0);
                chk("read.done",      32'(done),      32'd0);
                next_cycle();
            end
        end
        // DONE cycle: a legal start here must be ignored.
        rd_req      = 1'b0;
        start       = 1'b1;
        kernel_size = 8'd2;
        num_passes  = 8'd1;
        #1;
        chk("done.pulse",     32'(done),      32'd1);
        chk("done.busy",      32'(busy),      32'd1);
        chk("done.rd_active", 32'(rd_active), 32'd0);
        next_cycle();
        start = 1'b0;
        #1;
        chk("idle.done_clear", 32'(done),    32'd0);
        chk("idle.busy_fall",  32'(busy),    32'd0);
        chk("idle.s_ready",    32'(s_ready), 32'd0);
        next_cycle();
    endtask

    initial begin
        int k;
        int np;
        rstn        = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        kernel_size = '0;
        num_passes  = '0;
        s_data      = '0;
        s_valid     = 1'b0;
        rd_req      = 1'b0;

        #23;
        chk_all_zero("reset");
        #4 rstn = 1'b1;
        next_cycle();

        // Basic job with ramp data.
        do_start(3, 2);
        do_load(3, 12, 0);
        do_read(3, 2, 1'b0);

        // Stream backpressure.
        do_start(3, 2);
        do_load(3, 12, 1);
        do_read(3, 2, 1'b0);

        // Configuration rejects.
        do_reject(0, 1);
        do_reject(17, 1);
        do_reject(3, 0);

        // rd_req held through bursts.
        do_start(4, 3);
        do_load(4, 16, 2);
        do_read(4, 3, 1'b1);

        // Abort after 5 handshakes, then a fresh job must restart at buffer 0.
        do_start(3, 2);
        do_load(3, 5, 0);
        abort   = 1'b1;
        s_valid = 1'b1;
        #1;
        chk("abort.s_ready",   32'(s_ready),   32'd0);
        chk("abort.buf_flush", 32'(buf_flush), 32'd0);
        next_cycle();
        abort   = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort.idle_busy", 32'(busy),    32'd0);
            chk("abort.s_ready0",  32'(s_ready), 32'd0);
            chk("abort.no_done",   32'(done),    32'd0);
            next_cycle();
        end
        do_start(3, 1);
        do_load(3, 12, 0);
        do_read(3, 1, 1'b0);

        // Async reset mid-READ with start high beforehand.
        do_start(4, 2);
        do_load(4, 16, 0);
        rd_req = 1'b1;
        #1;
        chk("rst.rd_start", 32'(rd_start), 32'd1);
        next_cycle();
        rd_req = 1'b0;
        #1;
        chk("rst.in_read", 32'(rd_active), 32'd1);
        next_cycle();
        start       = 1'b1;
        kernel_size = 8'd4;
        num_passes  = 8'd2;
        s_valid     = 1'b1;
        s_data      = 16'hABCD;
        #1 rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        start   = 1'b0;
        s_valid = 1'b0;
        next_cycle();
        next_cycle();
        #2 rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            chk("post_rst.rd_start", 32'(rd_start), 32'd0);
            chk("post_rst.done",     32'(done),     32'd0);
            chk("post_rst.busy",     32'(busy),     32'd0);
        end
        next_cycle();

        // Boundary kernel sizes and random jobs.
        do_start(MK, 1);
        do_load(MK, NB * MK, 2);
        do_read(MK, 1, 1'b0);
        do_start(1, 2);
        do_load(1, NB, 2);
        do_read(1, 2, 1'b0);
        for (int j = 0; j < 4; j++) begin
            k  = $urandom_range(1, 6);
            np = $urandom_range(1, 3);
            do_start(k, np);
            do_load(k, NB * k, 2);
            do_read(k, np, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
